seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for a bank of common-anode 7-segment digits on the alarm-clock board.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan driver.
// Provides SEG_OFF (all segments dark, active-low) and hex_to_seg().
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_OFF;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bundle between the alarm-clock logic (master) and the scan driver (slave).
// Inputs: digits, dp_in, blank_mask, blink_mask, lz_en; outputs: seg, dp, an, frame_start.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    modport master (
        output digits, dp_in, blank_mask, blink_mask, lz_en,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  digits, dp_in, blank_mask, blink_mask, lz_en,
        output seg, dp, an, frame_start
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment decoder.
// Ports: nib_i (hex nibble), seg_o (active-low segments, seg_o[0]=a).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame input snapshot.
// Ports: clk, rst_n (async active-low), bus (slave: display inputs in, seg/dp/an/frame_start out).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYC    = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int ND = NUM_DIGITS;

    logic [SW-1:0]   slot_q, slot_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [FW-1:0]   frm_q, frm_d;
    logic            blink_q, blink_d;

    logic [4*ND-1:0] dig_q;
    logic [ND-1:0]   dpi_q;
    logic [ND-1:0]   blank_q;
    logic [ND-1:0]   blinkm_q;
    logic            lz_q;

    logic [ND-1:0]   an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            fs_q;

    logic            slot_wrap;
    logic            frame_wrap;
    logic            guard;
    logic [ND-1:0]   lz_sup;
    logic            lz_run;
    logic [ND-1:0]   dark;
    logic [3:0]      nib;
    logic [6:0]      hex_seg;

    assign slot_wrap  = (slot_q == SW'(REFRESH_DIV - 1));
    assign frame_wrap = slot_wrap && (idx_q == IW'(NUM_DIGITS - 1));
    assign guard      = (slot_q < SW'(GUARD_CYC));

    // Scan timing: slot counter, digit index, blink frame counter.
    always_comb begin
        slot_d  = slot_wrap ? '0 : slot_q + SW'(1);
        idx_d   = idx_q;
        frm_d   = frm_q;
        blink_d = blink_q;
        if (slot_wrap) begin
            idx_d = frame_wrap ? '0 : idx_q + IW'(1);
        end
        if (frame_wrap) begin
            if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                blink_d = ~blink_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end
    end

    // Leading-zero run from the top digit down; blanked digits
    // count as zero so a blanked high digit doesn't stop suppression.
    always_comb begin
        lz_sup = '0;
        lz_run = lz_q;
        for (int i = ND - 1; i >= 1; i--) begin
            lz_run    = lz_run &&
                        ((dig_q[4*i +: 4] == 4'h0) || blank_q[i]);
            lz_sup[i] = lz_run;
        end
    end

    assign dark = blank_q
                | (blinkm_q & {ND{blink_q}})
                | lz_sup;

    assign nib = dig_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!guard && !dark[idx_q]) begin
            an_d  = ~(ND'(1) << idx_q);
            seg_d = hex_seg;
            dp_d  = ~dpi_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            idx_q    <= '0;
            frm_q    <= '0;
            blink_q  <= 1'b0;
            dig_q    <= '0;
            dpi_q    <= '0;
            blank_q  <= '0;
            blinkm_q <= '0;
            lz_q     <= 1'b0;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            blink_q <= blink_d;
            // Snapshot only at the frame boundary so a frame never tears.
            if (frame_wrap) begin
                dig_q    <= bus.digits;
                dpi_q    <= bus.dp_in;
                blank_q  <= bus.blank_mask;
                blinkm_q <= bus.blink_mask;
                lz_q     <= bus.lz_en;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= frame_wrap;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-frame expected pictures are queued
// when inputs are captured at a frame boundary and compared slot by slot on display.
module tb_seg7_scan_driver;

    localparam int ND    = 8;
    localparam int RDIV  = 8;
    localparam int GUARD = 2;
    localparam int BF    = 2;
    localparam int FRAME = ND * RDIV;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    typedef slot_t [ND-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RDIV),
        .GUARD_CYC    (GUARD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hexc(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0: r = 7'h40; 4'h1: r = 7'h79;
            4'h2: r = 7'h24; 4'h3: r = 7'h30;
            4'h4: r = 7'h19; 4'h5: r = 7'h12;
            4'h6: r = 7'h02; 4'h7: r = 7'h78;
            4'h8: r = 7'h00; 4'h9: r = 7'h10;
            4'hA: r = 7'h08; 4'hB: r = 7'h03;
            4'hC: r = 7'h46; 4'hD: r = 7'h21;
            4'hE: r = 7'h06; default: r = 7'h0E;
        endcase
        return r;
    endfunction

    function automatic frame_t mk_frame(input logic [31:0] dg,
                                        input logic [7:0]  dpi,
                                        input logic [7:0]  bl,
                                        input logic [7:0]  bk,
                                        input logic        lz,
                                        input logic        ph);
        frame_t     f;
        logic       run;
        logic       dk;
        logic [3:0] n;
        run = lz;
        for (int i = ND - 1; i >= 0; i--) begin
            n = dg[4*i +: 4];
            if (i > 0) run = run && ((n == 4'h0) || bl[i]);
            else       run = 1'b0;
            dk = bl[i] || (bk[i] && ph) || run;
            if (dk) begin
                f[i].an  = 8'hFF;
                f[i].seg = 7'h7F;
                f[i].dp  = 1'b1;
            end else begin
                f[i].an  = 8'(~(8'h01 << i));
                f[i].seg = hexc(n);
                f[i].dp  = ~dpi[i];
            end
        end
        return f;
    endfunction

    logic [31:0] s_dig;
    logic [7:0]  s_dpi, s_bl, s_bk;
    logic        s_lz;

    // Inputs as the DUT sees them at each active edge.
    always @(posedge clk) begin
        s_dig = bus.digits;
        s_dpi = bus.dp_in;
        s_bl  = bus.blank_mask;
        s_bk  = bus.blink_mask;
        s_lz  = bus.lz_en;
    end

    int     pos = -1;
    logic   fs_prev = 1'b0;
    int     fcnt = 0;
    logic   ph = 1'b0;
    frame_t cur;
    frame_t sbq[$];
    slot_t  e;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_an", 32'(bus.an), 32'hFF);
            chk("rst_seg", 32'(bus.seg), 32'h7F);
            chk("rst_dp", 32'(bus.dp), 32'h1);
            chk("rst_fs", 32'(bus.frame_start), 32'h0);
            pos     = -1;
            fs_prev = 1'b0;
            fcnt    = 0;
            ph      = 1'b0;
            sbq.delete();
            cur = mk_frame(32'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
        end else begin
            if (fs_prev) begin
                pos = 0;
                if (sbq.size() > 0) cur = sbq.pop_front();
            end else begin
                pos = pos + 1;
            end
            if (pos >= FRAME) pos = 0;
            if ((pos % RDIV) < GUARD) begin
                e.an  = 8'hFF;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e = cur[pos / RDIV];
            end
            chk("an", 32'(bus.an), 32'(e.an));
            chk("seg", 32'(bus.seg), 32'(e.seg));
            chk("dp", 32'(bus.dp), 32'(e.dp));
            chk("frame_start", 32'(bus.frame_start),
                32'(pos == FRAME - 1));
            chk("one_anode", 32'($countones(~bus.an) <= 1), 32'h1);
            fs_prev = bus.frame_start;
            if (bus.frame_start) begin
                if (fcnt == BF - 1) begin
                    fcnt = 0;
                    ph   = ~ph;
                end else begin
                    fcnt = fcnt + 1;
                end
                sbq.push_back(mk_frame(s_dig, s_dpi, s_bl, s_bk, s_lz, ph));
            end
        end
    end

    task automatic run_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        bus.digits     = 32'h01234567;
        bus.dp_in      = 8'h00;
        bus.blank_mask = 8'h00;
        bus.blink_mask = 8'h00;
        bus.lz_en      = 1'b0;
        run_cyc(3);
        rst_n = 1'b1;
        run_cyc(FRAME * 3);

        bus.digits = 32'h00000050;
        bus.lz_en  = 1'b1;
        run_cyc(FRAME * 3);
        bus.digits = 32'h00000000;
        run_cyc(FRAME * 2);

        bus.digits = 32'h11111111;
        bus.lz_en  = 1'b0;
        run_cyc(FRAME * 2);
        for (int k = 0; k < 2 * FRAME && !bus.frame_start; k++)
            @(negedge clk);
        chk("sync_fs", 32'(bus.frame_start), 32'h1);
        run_cyc(20);
        bus.digits = 32'h22222222;
        run_cyc(FRAME * 2);

        bus.digits     = 32'h89ABCDEF;
        bus.blink_mask = 8'h03;
        run_cyc(FRAME * 6);

        bus.blink_mask = 8'h00;
        bus.blank_mask = 8'h20;
        bus.dp_in      = 8'hA5;
        bus.lz_en      = 1'b1;
        bus.digits     = 32'h00500123;
        run_cyc(FRAME * 3);

        for (int k = 0; k < 2 * FRAME && bus.an != 8'hFB; k++)
            @(negedge clk);
        chk("find_fb", 32'(bus.an), 32'hFB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an", 32'(bus.an), 32'hFF);
        chk("async_seg", 32'(bus.seg), 32'h7F);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_cyc(FRAME * 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
